// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Sits behind a UART receiver. It hunts for a sync byte and parses
// length-prefixed frames (SYNC, LEN, payload, CSUM). CSUM is the XOR of LEN
// and all payload bytes. Good frames are buffered and streamed out over
// valid/ready. Length, checksum, timeout and overrun errors are reported
// as registered one-cycle pulses.
module uart_rx_frame_ctrl #(
    parameter int MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int TIMEOUT_CLKS = 4340
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_rx_dv,
    input  logic [7:0] in_rx_byte,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       in_ready,
    output logic       out_last,
    output logic [7:0] out_len,
    output logic       out_busy,
    output logic       out_err_len,
    output logic       out_err_csum,
    output logic       out_err_timeout,
    output logic       out_err_overrun
);

    localparam int IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int BUF_DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t      state_r, state_next_s;
    logic [7:0]  len_r, len_next_s;
    logic [7:0]  csum_r, csum_next_s;
    logic [7:0]  wr_idx_r, wr_idx_next_s;
    logic [7:0]  rd_idx_r, rd_idx_next_s;
    logic [15:0] gap_r, gap_next_s;
    logic        buf_we_s;
    logic        err_len_s, err_csum_s, err_timeout_s, err_overrun_s;
    logic        drain_next_s;

    logic [7:0]  buf_r [BUF_DEPTH];

    logic [7:0]  out_data_r, out_len_r;
    logic        out_valid_r, out_last_r, out_busy_r;
    logic        err_len_r, err_csum_r, err_timeout_r, err_overrun_r;

    // Next-state, index, checksum and gap-counter logic for the frame parser.
    always_comb begin
        state_next_s  = state_r;
        len_next_s    = len_r;
        csum_next_s   = csum_r;
        wr_idx_next_s = wr_idx_r;
        rd_idx_next_s = rd_idx_r;
        gap_next_s    = gap_r;
        buf_we_s      = 1'b0;
        err_len_s     = 1'b0;
        err_csum_s    = 1'b0;
        err_timeout_s = 1'b0;
        err_overrun_s = 1'b0;
        case (state_r)
            ST_HUNT: begin
                gap_next_s = 16'd0;
                if (in_rx_dv && (in_rx_byte == SYNC_BYTE)) begin
                    state_next_s = ST_LEN;
                end else begin
                    state_next_s = ST_HUNT;
                end
            end
            ST_LEN, ST_PAYLOAD, ST_CSUM: begin
                if (in_rx_dv) begin
                    gap_next_s = 16'd0;
                    if (state_r == ST_LEN) begin
                        if ((in_rx_byte == 8'd0) || (in_rx_byte > 8'(MAX_LEN))) begin
                            err_len_s    = 1'b1;
                            state_next_s = ST_HUNT;
                        end else begin
                            len_next_s    = in_rx_byte;
                            csum_next_s   = in_rx_byte;
                            wr_idx_next_s = 8'd0;
                            state_next_s  = ST_PAYLOAD;
                        end
                    end else if (state_r == ST_PAYLOAD) begin
                        buf_we_s    = 1'b1;
                        csum_next_s = csum_r ^ in_rx_byte;
                        if (wr_idx_r == (len_r - 8'd1)) begin
                            state_next_s = ST_CSUM;
                        end else begin
                            wr_idx_next_s = wr_idx_r + 8'd1;
                        end
                    end else begin
                        if (in_rx_byte == csum_r) begin
                            rd_idx_next_s = 8'd0;
                            state_next_s  = ST_DRAIN;
                        end else begin
                            err_csum_s   = 1'b1;
                            state_next_s = ST_HUNT;
                        end
                    end
                end else if (gap_r == 16'(TIMEOUT_CLKS - 1)) begin
                    err_timeout_s = 1'b1;
                    gap_next_s    = 16'd0;
                    state_next_s  = ST_HUNT;
                end else begin
                    gap_next_s = gap_r + 16'd1;
                end
            end
            ST_DRAIN: begin
                gap_next_s = 16'd0;
                // A byte arriving while draining cannot be stored; it is dropped.
                if (in_rx_dv) begin
                    err_overrun_s = 1'b1;
                end else begin
                    err_overrun_s = 1'b0;
                end
                if (out_valid_r && in_ready) begin
                    if (out_last_r) begin
                        state_next_s = ST_HUNT;
                    end else begin
                        rd_idx_next_s = rd_idx_r + 8'd1;
                    end
                end else begin
                    rd_idx_next_s = rd_idx_r;
                end
            end
            default: begin
                state_next_s = ST_HUNT;
            end
        endcase
        drain_next_s = (state_next_s == ST_DRAIN);
    end

    // Parser state, counters and registered outputs; outputs are computed from
    // next-state values so they line up with the state they describe.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_r       <= ST_HUNT;
            len_r         <= 8'd0;
            csum_r        <= 8'd0;
            wr_idx_r      <= 8'd0;
            rd_idx_r      <= 8'd0;
            gap_r         <= 16'd0;
            out_data_r    <= 8'd0;
            out_len_r     <= 8'd0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_busy_r    <= 1'b0;
            err_len_r     <= 1'b0;
            err_csum_r    <= 1'b0;
            err_timeout_r <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            len_r         <= len_next_s;
            csum_r        <= csum_next_s;
            wr_idx_r      <= wr_idx_next_s;
            rd_idx_r      <= rd_idx_next_s;
            gap_r         <= gap_next_s;
            out_valid_r   <= drain_next_s;
            out_data_r    <= drain_next_s ? buf_r[rd_idx_next_s[IDX_W-1:0]] : 8'd0;
            out_last_r    <= drain_next_s && (rd_idx_next_s == (len_next_s - 8'd1));
            out_len_r     <= drain_next_s ? len_next_s : 8'd0;
            out_busy_r    <= (state_next_s != ST_HUNT);
            err_len_r     <= err_len_s;
            err_csum_r    <= err_csum_s;
            err_timeout_r <= err_timeout_s;
            err_overrun_r <= err_overrun_s;
        end
    end

    // Payload storage; deliberately not reset, only written while in PAYLOAD.
    always_ff @(posedge in_clk) begin
        if (buf_we_s) begin
            buf_r[wr_idx_r[IDX_W-1:0]] <= in_rx_byte;
        end
    end

    assign out_data        = out_data_r;
    assign out_valid       = out_valid_r;
    assign out_last        = out_last_r;
    assign out_len         = out_len_r;
    assign out_busy        = out_busy_r;
    assign out_err_len     = err_len_r;
    assign out_err_csum    = err_csum_r;
    assign out_err_timeout = err_timeout_r;
    assign out_err_overrun = err_overrun_r;

endmodule
